csa_resolve_seq: RTL and testbench

- Sequential carry-propagate resolver for carry-save pairs, i.e. the sum vector (Y) and carry vector (X) produced by banks of full-adder/half-adder cells.
- Converts a pair into a plain binary result, CHUNK bits per cycle, using one registered carry. This trades latency for a short carry chain.
- Sits downstream of compressor trees in multiplier/accumulator datapaths built on the platform adder cells.
- Valid/ready on both sides.

---
 rtl/csa_resolve_seq.sv | 131 +++++++++++++
 tb/tb_csa_resolve_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_seq.sv
// Sequential carry-save to binary resolver: CHUNK bits per cycle through one registered carry.
// Optional early exit when the remaining upper chunks are all zero: define CSA_RESOLVE_EARLY_EN.
module csa_resolve_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_result
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  if (CHUNK == 0 || WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("csa_resolve_seq: CHUNK must be nonzero and divide WIDTH (WIDTH >= 2)");
  end

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             hb_q, hb_d;
  logic             c_q, c_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH+1:0] result_q, result_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] work_next;
  logic [1:0]       top_bits;
  logic             finish;

`ifdef CSA_RESOLVE_EARLY_EN
  logic upper_zero;
`endif

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;

  always_comb begin
    a_chunk   = a_q[k_q*CHUNK +: CHUNK];
    b_chunk   = b_q[k_q*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
    work_next = work_q;
    work_next[k_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    top_bits  = {1'b0, chunk_sum[CHUNK]} + {1'b0, hb_q};
`ifdef CSA_RESOLVE_EARLY_EN
    upper_zero = 1'b1;
    for (int unsigned j = 0; j < N; j++) begin
      if (j > 32'(k_q) && (|(a_q[j*CHUNK +: CHUNK] | b_q[j*CHUNK +: CHUNK]))) begin
        upper_zero = 1'b0;
      end
    end
    finish = (k_q == KLast) || (!chunk_sum[CHUNK] && !hb_q && upper_zero);
`else
    finish = (k_q == KLast);
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    hb_d     = hb_q;
    c_d      = c_q;
    k_d      = k_q;
    work_d   = work_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_sum;
          b_d     = {in_carry[WIDTH-2:0], 1'b0};
          hb_d    = in_carry[WIDTH-1];
          c_d     = 1'b0;
          k_d     = '0;
          // Cleared here so chunks skipped by an early exit read as zero.
          work_d  = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        c_d    = chunk_sum[CHUNK];
        k_d    = k_q + KW'(1);
        work_d = work_next;
        if (finish) begin
          result_d = {top_bits, work_next};
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      hb_q     <= 1'b0;
      c_q      <= 1'b0;
      k_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hb_q     <= hb_d;
      c_q      <= c_d;
      k_q      <= k_d;
      work_q   <= work_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Directed and random self-checking bench for csa_resolve_seq at WIDTH=16, CHUNK=4.
module tb_csa_resolve_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] out_result;

  int n_checks = 0;
  int n_errors = 0;

  csa_resolve_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Present a pair, wait for acceptance, then count cycles until out_valid.
  task automatic xfer(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                      output logic [WIDTH+1:0] r, output int lat);
    int guard;
    @(negedge clk);
    in_sum   = s;
    in_carry = c;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = out_result;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drop_valid", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  logic [WIDTH+1:0] res, held;
  logic [WIDTH+1:0] exp_r;
  logic [WIDTH-1:0] rs, rc;
  int lat, guard;
  int exp_lat_first;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sum    = 16'h0003;
    in_carry  = 16'h0002;
    out_ready = 1'b0;

    // Reset held with in_valid high: must stay idle and empty.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("accept_after_rst", 32'(in_ready), 32'd0);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("rst_pair_result", 32'(out_result), 32'h00007);
    release_result();

    // Carry ripple through two chunks; early exit possible after chunk 2.
`ifdef CSA_RESOLVE_EARLY_EN
    exp_lat_first = 3;
`else
    exp_lat_first = 4;
`endif
    xfer(16'h00FF, 16'h0001, res, lat);
    check("ff_result", 32'(res), 32'h00101);
    check("ff_latency", 32'(lat), 32'(exp_lat_first));
    release_result();

    // All-ones boundary, then stall in DONE with in_valid noise.
    xfer(16'hFFFF, 16'hFFFF, res, lat);
    check("ones_result", 32'(res), 32'h2FFFD);
    check("ones_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_sum   = 16'(16'h1111 * i);
      in_carry = 16'hA5A5;
      @(posedge clk);
      #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_result", 32'(out_result), 32'h2FFFD);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_result();
    check("post_stall_hold", 32'(out_result), 32'h2FFFD);

    // Reset during the second ADD cycle discards the in-flight pair.
    @(negedge clk);
    in_sum   = 16'hFFFF;
    in_carry = 16'hFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_result", 32'(out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    xfer(16'h1234, 16'h0001, res, lat);
    check("post_rst_result", 32'(res), 32'h01236);
    check("post_rst_latency", 32'(lat), 32'd4);
    release_result();

    // Random pairs with random consumer back-pressure.
    for (int n = 0; n < 500; n++) begin
      rs = 16'($urandom);
      rc = 16'($urandom);
      if (n % 50 == 0) rs = '0;
      if (n % 50 == 1) rc = '0;
      exp_r = {2'b00, rs} + {1'b0, rc, 1'b0};
      xfer(rs, rc, res, lat);
      check("rand_valid", 32'(out_valid), 32'd1);
      check("rand_result", 32'(res), 32'(exp_r));
      held  = out_result;
      guard = 0;
      while (out_valid && guard < 100) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        if (out_valid) check("rand_hold", 32'(out_result), 32'(held));
        guard++;
      end
      check("rand_drained", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
